// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int SHA256_ROUNDS   = 64;
  localparam int SHA256_W_DIRECT = 16;
  localparam int SHA256_CTRL_LAT = 67;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } sha256_ctrl_state_t;

endpackage

// File: rtl/sha256_round_cnt.sv
// 6-bit round counter with clear, enable and terminal-count flag.
// Latency: count updates one cycle after en_i; last_o is combinational from the count.
// Backpressure: none; clear wins over enable.
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int LAST = SHA256_ROUNDS - 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] cnt_o,
  output logic       last_o
);

  // Round index register: reset/clear to zero, otherwise step when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= 6'd0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 6'd1;
    end
  end

  assign last_o = (cnt_o == 6'(LAST));

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for the SHA-256 compression datapath: block accept, 64 rounds, H update, digest handshake.
// Latency: accept at T -> LOAD T+1, rounds T+2..T+65, FINAL T+66, digest_valid/blk_ready at T+67.
// Backpressure: one block in flight; blk_ready_o low until the block retires, DONE holds until digest_ready_i.
// Optional abort port enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS   = SHA256_ROUNDS,
  parameter int W_DIRECT = SHA256_W_DIRECT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       blk_valid_i,
  input  logic       blk_first_i,
  input  logic       blk_last_i,
  output logic       blk_ready_o,
  input  logic       digest_ready_i,
  output logic       digest_valid_o,
  output logic       k_load_o,
  output logic       k_shift_o,
  output logic       w_sel_o,
  output logic       st_init_o,
  output logic       st_en_o,
  output logic       h_init_o,
  output logic       h_upd_o,
  output logic [5:0] round_o,
  output logic       busy_o
`ifdef SHA256_CTRL_ABORT_EN
  ,
  input  logic       abort_i
`endif
);

  localparam logic [5:0] W_DIRECT_C = 6'(W_DIRECT);

  sha256_ctrl_state_t state_q, state_d;

  logic chain_q;   // a previous non-last block left H holding a chaining value
  logic first_q;   // current block starts from the IV
  logic last_q;    // current block ends the message
  logic accept;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_last;
  logic abort_w;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  sha256_round_cnt #(
    .LAST (ROUNDS - 1)
  ) u_round_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (round_o),
    .last_o (cnt_last)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; abort overrides every non-idle transition.
  always_comb begin
    state_d        = state_q;
    blk_ready_o    = 1'b0;
    digest_valid_o = 1'b0;
    k_load_o       = 1'b0;
    k_shift_o      = 1'b0;
    w_sel_o        = 1'b0;
    st_init_o      = 1'b0;
    st_en_o        = 1'b0;
    h_init_o       = 1'b0;
    h_upd_o        = 1'b0;
    accept         = 1'b0;
    cnt_clr        = 1'b1;
    cnt_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        blk_ready_o = ~rst_i & ~abort_w;
        if (blk_valid_i && !rst_i && !abort_w) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        st_init_o = 1'b1;
        k_load_o  = 1'b1;
        h_init_o  = first_q;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        st_en_o   = 1'b1;
        k_shift_o = 1'b1;
        w_sel_o   = (round_o >= W_DIRECT_C);
        cnt_en    = 1'b1;
        cnt_clr   = cnt_last;
        if (cnt_last) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        h_upd_o = ~abort_w;
        state_d = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_w && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  // Per-block flags and the chaining marker; a first block or an unchained start reloads the IV.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        first_q <= blk_first_i | ~chain_q;
        last_q  <= blk_last_i;
      end
      if (abort_w && state_q != ST_IDLE) begin
        chain_q <= 1'b0;
      end else if (state_q == ST_FINAL) begin
        chain_q <= ~last_q;
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl; abort cases built when SHA256_CTRL_ABORT_EN is defined.
// Latency: checks full 67-cycle block timing strobe by strobe.
// Backpressure: exercises digest hold, held blk_valid and mid-block reset.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blk_valid = 1'b0;
  logic       blk_first = 1'b0;
  logic       blk_last = 1'b0;
  logic       blk_ready;
  logic       digest_ready = 1'b0;
  logic       digest_valid;
  logic       k_load, k_shift, w_sel, st_init, st_en, h_init, h_upd, busy;
  logic [5:0] round;
`ifdef SHA256_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .blk_valid_i    (blk_valid),
    .blk_first_i    (blk_first),
    .blk_last_i     (blk_last),
    .blk_ready_o    (blk_ready),
    .digest_ready_i (digest_ready),
    .digest_valid_o (digest_valid),
    .k_load_o       (k_load),
    .k_shift_o      (k_shift),
    .w_sel_o        (w_sel),
    .st_init_o      (st_init),
    .st_en_o        (st_en),
    .h_init_o       (h_init),
    .h_upd_o        (h_upd),
    .round_o        (round),
    .busy_o         (busy)
`ifdef SHA256_CTRL_ABORT_EN
    ,
    .abort_i        (abort)
`endif
  );

  // Output vector: {busy, blk_ready, digest_valid, k_load, k_shift, w_sel, st_init, st_en, h_init, h_upd}
  logic [9:0] vec;
  assign vec = {busy, blk_ready, digest_valid, k_load, k_shift, w_sel, st_init, st_en, h_init, h_upd};

  localparam logic [9:0] V_ZERO  = 10'b0000000000;
  localparam logic [9:0] V_IDLE  = 10'b0100000000;
  localparam logic [9:0] V_FINAL = 10'b1000000001;
  localparam logic [9:0] V_DONE  = 10'b1010000000;

  function automatic logic [9:0] v_load(input logic h);
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, h, 1'b0};
  endfunction

  function automatic logic [9:0] v_round(input logic w);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block from IDLE and walk it to its end state.
  task automatic run_block(input logic first, input logic last, input logic exp_h, input logic exp_done);
    blk_valid = 1'b1;
    blk_first = first;
    blk_last  = last;
    check("accept_ready", {31'd0, blk_ready}, 32'd1);
    tick();
    blk_valid = 1'b0;
    check("load_vec", {22'd0, vec}, {22'd0, v_load(exp_h)});
    check("load_round", {26'd0, round}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      tick();
      check("round_vec", {22'd0, vec}, {22'd0, v_round(i >= 16)});
      check("round_idx", {26'd0, round}, i);
    end
    tick();
    check("final_vec", {22'd0, vec}, {22'd0, V_FINAL});
    check("final_round", {26'd0, round}, 32'd0);
    tick();
    check("end_vec", {22'd0, vec}, {22'd0, (exp_done ? V_DONE : V_IDLE)});
  endtask

  task automatic release_digest();
    digest_ready = 1'b1;
    check("done_before_rdy", {22'd0, vec}, {22'd0, V_DONE});
    tick();
    digest_ready = 1'b0;
    check("idle_after_rdy", {22'd0, vec}, {22'd0, V_IDLE});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int overlap;
    int acc_idx[$];

    // Reset state
    tick();
    tick();
    check("reset_vec", {22'd0, vec}, {22'd0, V_ZERO});
    check("reset_round", {26'd0, round}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {22'd0, vec}, {22'd0, V_IDLE});
    tick();

    // Single block with digest held for a few cycles; ready outside DONE is ignored
    digest_ready = 1'b1;
    tick();
    check("idle_rdy_ignored", {22'd0, vec}, {22'd0, V_IDLE});
    digest_ready = 1'b0;
    run_block(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold", {22'd0, vec}, {22'd0, V_DONE});
    end
    release_digest();

    // Two-block chain: second block continues from H
    run_block(1'b1, 1'b0, 1'b1, 1'b0);
    run_block(1'b0, 1'b1, 1'b0, 1'b1);
    release_digest();

    // Mid-chain first restarts from the IV
    run_block(1'b1, 1'b0, 1'b1, 1'b0);
    run_block(1'b1, 1'b1, 1'b1, 1'b1);
    release_digest();

    // Reset at round 30 of a chained block
    run_block(1'b1, 1'b0, 1'b1, 1'b0);
    blk_valid = 1'b1;
    blk_first = 1'b0;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    check("chain_load_vec", {22'd0, vec}, {22'd0, v_load(1'b0)});
    for (int i = 0; i <= 30; i++) tick();
    check("pre_rst_round", {26'd0, round}, 32'd30);
    rst = 1'b1;
    tick();
    check("mid_rst_vec", {22'd0, vec}, {22'd0, V_ZERO});
    check("mid_rst_round", {26'd0, round}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_idle", {22'd0, vec}, {22'd0, V_IDLE});
    run_block(1'b0, 1'b1, 1'b1, 1'b1);
    release_digest();

    // blk_valid held high: one accept while digest pending, never ready with digest_valid
    blk_valid = 1'b1;
    blk_first = 1'b1;
    blk_last  = 1'b1;
    accepts = 0;
    overlap = 0;
    for (int i = 0; i < 150; i++) begin
      if (blk_valid && blk_ready) accepts++;
      if (blk_ready && digest_valid) overlap++;
      tick();
    end
    check("held_accepts", accepts, 32'd1);
    check("held_dv", {31'd0, digest_valid}, 32'd1);
    digest_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (blk_valid && blk_ready) acc_idx.push_back(i);
      if (blk_ready && digest_valid) overlap++;
      tick();
    end
    blk_valid = 1'b0;
    check("held_acc_count", acc_idx.size(), 32'd3);
    if (acc_idx.size() >= 2) check("held_gap", acc_idx[1] - acc_idx[0], 32'd68);
    else check("held_gap", 32'd0, 32'd68);
    check("held_overlap", overlap, 32'd0);
    for (int i = 0; i < 100 && busy; i++) tick();
    check("held_drain", {31'd0, busy}, 32'd0);
    digest_ready = 1'b0;
    tick();

`ifdef SHA256_CTRL_ABORT_EN
    // Abort at round 5 of a chained block
    run_block(1'b1, 1'b0, 1'b1, 1'b0);
    blk_valid = 1'b1;
    blk_first = 1'b0;
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    check("abort_load_vec", {22'd0, vec}, {22'd0, v_load(1'b0)});
    for (int i = 0; i <= 5; i++) tick();
    check("abort_round", {26'd0, round}, 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    check("abort_idle_vec", {22'd0, vec}, {22'd0, V_IDLE});
    check("abort_idle_round", {26'd0, round}, 32'd0);
    abort = 1'b1;
    #1;
    check("abort_idle_ready", {31'd0, blk_ready}, 32'd0);
    abort = 1'b0;
    #1;
    run_block(1'b0, 1'b1, 1'b1, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    check("abort_done_vec", {22'd0, vec}, {22'd0, V_IDLE});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
